// File: rtl/chime_ctrl_if.sv
// Chime controller signal bundle: time-of-day inputs, mute controls and buzzer outputs.
// Signalling: there is no valid/ready handshake on this bundle. Every input is a level
// sampled on each rising clk edge, and every output is a registered level that changes
// only on a rising clk edge.
interface chime_ctrl_if;
  logic       en;
  logic [6:0] set_time;
  logic [6:0] S_in;
  logic [6:0] M_in;
  logic [4:0] H_in;
  logic       buzz;
  logic       busy;
  logic [2:0] dbg_state;

  modport master (
    output en, set_time, S_in, M_in, H_in,
    input  buzz, busy, dbg_state
  );

  modport slave (
    input  en, set_time, S_in, M_in, H_in,
    output buzz, busy, dbg_state
  );
endinterface

// File: rtl/chime_ctrl.sv
// Hourly chime controller: pips before the hour, then one long tone or hour strikes.
module chime_ctrl #(
  parameter int TONE_HI_DIV    = 50000,
  parameter int TONE_LO_DIV    = 62500,
  parameter int PRE_BEEPS      = 5,
  parameter int BEEP_CYC       = 25_000_000,
  parameter int TOP_CYC        = 50_000_000,
  parameter int STRIKE_EN      = 0,
  parameter int STRIKE_ON_CYC  = 25_000_000,
  parameter int STRIKE_GAP_CYC = 25_000_000
) (
  input logic         clk,
  input logic         rst,
  chime_ctrl_if.slave bus
);

  localparam int DUR_M1  = (BEEP_CYC > TOP_CYC) ? BEEP_CYC : TOP_CYC;
  localparam int DUR_M2  = (STRIKE_ON_CYC > STRIKE_GAP_CYC) ? STRIKE_ON_CYC : STRIKE_GAP_CYC;
  localparam int DUR_MAX = (DUR_M1 > DUR_M2) ? DUR_M1 : DUR_M2;
  localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
  localparam int DIV_MAX = (TONE_HI_DIV > TONE_LO_DIV) ? TONE_HI_DIV : TONE_LO_DIV;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [DUR_W-1:0] BEEP_LAST = DUR_W'(BEEP_CYC - 1);
  localparam logic [DUR_W-1:0] TOP_LAST  = DUR_W'(TOP_CYC - 1);
  localparam logic [DUR_W-1:0] ON_LAST   = DUR_W'(STRIKE_ON_CYC - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(STRIKE_GAP_CYC - 1);
  localparam logic [DIV_W-1:0] HI_LAST   = DIV_W'(TONE_HI_DIV - 1);
  localparam logic [DIV_W-1:0] LO_LAST   = DIV_W'(TONE_LO_DIV - 1);
  // First second of the pip window; 60 when PRE_BEEPS is 0, which no legal second reaches.
  localparam logic [6:0]       PIP_FIRST = 7'(60 - 2 * PRE_BEEPS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PIP      = 3'd1,
    S_TOP      = 3'd2,
    S_STRK_ON  = 3'd3,
    S_STRK_GAP = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;
  logic [4:0]       n_q, n_d;
  logic [6:0]       s_q;
  logic             buzz_q, busy_q;

  logic             mute, new_sec, pip_trig, top_trig, tone_d;
  logic [4:0]       h_mod, n_load;
  logic [DIV_W-1:0] div_last;

  assign mute     = !bus.en || (bus.set_time != 7'd0);
  assign new_sec  = (bus.S_in != s_q) && !mute;
  assign pip_trig = new_sec && (bus.M_in == 7'd59) && !bus.S_in[0] &&
                    (bus.S_in <= 7'd59) && (bus.S_in >= PIP_FIRST);
  assign top_trig = new_sec && (bus.M_in == 7'd0) && (bus.S_in == 7'd0);
  // Twelve-hour strike count; midnight and noon strike twelve.
  assign h_mod    = bus.H_in % 5'd12;
  assign n_load   = (h_mod == 5'd0) ? 5'd12 : h_mod;
  assign div_last = (state_q == S_PIP) ? HI_LAST : LO_LAST;
  assign tone_d   = (state_d == S_PIP) || (state_d == S_TOP) || (state_d == S_STRK_ON);

  // Next-state, duration, tone-divider and strike-count logic; triggers pre-empt any activity.
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    div_d   = div_q;
    phase_d = phase_q;
    n_d     = n_q;
    if (mute) begin
      state_d = S_IDLE;
      dur_d   = '0;
    end else if (top_trig) begin
      dur_d   = '0;
      div_d   = '0;
      phase_d = 1'b1;
      if (STRIKE_EN != 0) begin
        state_d = S_STRK_ON;
        n_d     = n_load;
      end else begin
        state_d = S_TOP;
      end
    end else if (pip_trig) begin
      state_d = S_PIP;
      dur_d   = '0;
      div_d   = '0;
      phase_d = 1'b1;
    end else begin
      if ((state_q == S_PIP) || (state_q == S_TOP) || (state_q == S_STRK_ON)) begin
        if (div_q == div_last) begin
          div_d   = '0;
          phase_d = ~phase_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      case (state_q)
        S_PIP: begin
          if (dur_q == BEEP_LAST) begin
            state_d = S_IDLE;
            dur_d   = '0;
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        S_TOP: begin
          if (dur_q == TOP_LAST) begin
            state_d = S_IDLE;
            dur_d   = '0;
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        S_STRK_ON: begin
          if (dur_q == ON_LAST) begin
            dur_d   = '0;
            n_d     = n_q - 5'd1;
            state_d = (n_q <= 5'd1) ? S_IDLE : S_STRK_GAP;
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        S_STRK_GAP: begin
          if (dur_q == GAP_LAST) begin
            state_d = S_STRK_ON;
            dur_d   = '0;
            div_d   = '0;
            phase_d = 1'b1;
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          dur_d   = '0;
        end
      endcase
    end
  end

  // State and output registers; the seconds copy tracks S_in even in reset so release is silent.
  always_ff @(posedge clk) begin
    s_q <= bus.S_in;
    if (rst) begin
      state_q <= S_IDLE;
      dur_q   <= '0;
      div_q   <= '0;
      phase_q <= 1'b0;
      n_q     <= '0;
      buzz_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      n_q     <= n_d;
      buzz_q  <= tone_d & phase_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign bus.buzz      = buzz_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_chime_ctrl.sv
// Directed bench for chime_ctrl: three instances share the time inputs.
// a: single top tone, 5 pips; b: strike mode; c: 2 pips.
module tb_chime_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  chime_ctrl_if if_a ();
  chime_ctrl_if if_b ();
  chime_ctrl_if if_c ();

  chime_ctrl #(.TONE_HI_DIV(4), .TONE_LO_DIV(5), .PRE_BEEPS(5), .BEEP_CYC(20), .TOP_CYC(40),
               .STRIKE_EN(0), .STRIKE_ON_CYC(10), .STRIKE_GAP_CYC(6))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  chime_ctrl #(.TONE_HI_DIV(4), .TONE_LO_DIV(5), .PRE_BEEPS(5), .BEEP_CYC(20), .TOP_CYC(40),
               .STRIKE_EN(1), .STRIKE_ON_CYC(10), .STRIKE_GAP_CYC(6))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  chime_ctrl #(.TONE_HI_DIV(4), .TONE_LO_DIV(5), .PRE_BEEPS(2), .BEEP_CYC(20), .TOP_CYC(40),
               .STRIKE_EN(0), .STRIKE_ON_CYC(10), .STRIKE_GAP_CYC(6))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  wire [2:0] busy_all = {if_c.busy, if_b.busy, if_a.busy};
  wire [2:0] buzz_all = {if_c.buzz, if_b.buzz, if_a.buzz};

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [6:0] st, input logic [6:0] s,
                       input logic [6:0] m, input logic [4:0] h);
    if_a.en = e; if_a.set_time = st; if_a.S_in = s; if_a.M_in = m; if_a.H_in = h;
    if_b.en = e; if_b.set_time = st; if_b.S_in = s; if_b.M_in = m; if_b.H_in = h;
    if_c.en = e; if_c.set_time = st; if_c.S_in = s; if_c.M_in = m; if_c.H_in = h;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 7'd0, 7'd0, 7'd0, 5'd0);
    repeat (3) tick();
    n_checks++;
    if (busy_all !== 3'b000) begin n_fail++; $display("FAIL reset_busy got %b exp 000", busy_all); end
    n_checks++;
    if (buzz_all !== 3'b000) begin n_fail++; $display("FAIL reset_buzz got %b exp 000", buzz_all); end
    n_checks++;
    if (if_b.dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", if_b.dbg_state); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (busy_all !== 3'b000) begin n_fail++; $display("FAIL reset_release_busy cyc %0d got %b exp 000", i, busy_all); end
    end
  endtask

  task automatic test_pip();
    logic exp_buzz;
    drive(1'b1, 7'd0, 7'd49, 7'd59, 5'd0);
    repeat (3) tick();
    n_checks++;
    if (busy_all !== 3'b000) begin n_fail++; $display("FAIL pip_pre_busy got %b exp 000", busy_all); end
    drive(1'b1, 7'd0, 7'd50, 7'd59, 5'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_buzz = ((i / 4) % 2) == 0;
      n_checks++;
      if (if_a.busy !== 1'b1) begin n_fail++; $display("FAIL pip_busy cyc %0d got %b exp 1", i, if_a.busy); end
      n_checks++;
      if (if_a.buzz !== exp_buzz) begin n_fail++; $display("FAIL pip_buzz cyc %0d got %b exp %b", i, if_a.buzz, exp_buzz); end
      n_checks++;
      if (if_c.busy !== 1'b0) begin n_fail++; $display("FAIL pip_c_busy cyc %0d got %b exp 0", i, if_c.busy); end
    end
    tick();
    n_checks++;
    if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL pip_end_busy got %b exp 0", if_a.busy); end
    n_checks++;
    if (if_a.buzz !== 1'b0) begin n_fail++; $display("FAIL pip_end_buzz got %b exp 0", if_a.buzz); end
  endtask

  task automatic test_pip_window();
    // Seconds 48..59 at minute 59: expected pip for PRE_BEEPS=5 (a) and PRE_BEEPS=2 (c)
    logic exp_a [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic exp_c [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 7'd0, 7'(48 + k), 7'd59, 5'd0);
      tick();
      n_checks++;
      if (if_a.busy !== exp_a[k]) begin n_fail++; $display("FAIL window_a sec %0d got %b exp %b", 48 + k, if_a.busy, exp_a[k]); end
      n_checks++;
      if (if_c.busy !== exp_c[k]) begin n_fail++; $display("FAIL window_c sec %0d got %b exp %b", 48 + k, if_c.busy, exp_c[k]); end
      repeat (22) tick();
    end
    // Out-of-range second never pips
    drive(1'b1, 7'd0, 7'd62, 7'd59, 5'd0);
    tick();
    n_checks++;
    if (busy_all !== 3'b000) begin n_fail++; $display("FAIL window_sec62 got %b exp 000", busy_all); end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 7'd0, 7'd49, 7'd59, 5'd0);
    repeat (25) tick();
    drive(1'b1, 7'd0, 7'd50, 7'd59, 5'd0);
    repeat (20) tick();
    n_checks++;
    if (if_a.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_last_busy got %b exp 1", if_a.busy); end
    drive(1'b1, 7'd0, 7'd52, 7'd59, 5'd0);
    tick();
    n_checks++;
    if (if_a.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy got %b exp 1", if_a.busy); end
    n_checks++;
    if (if_a.buzz !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_buzz got %b exp 1", if_a.buzz); end
    repeat (4) tick();
    n_checks++;
    if (if_a.buzz !== 1'b0) begin n_fail++; $display("FAIL b2b_phase cyc4 got %b exp 0", if_a.buzz); end
    repeat (15) tick();
    n_checks++;
    if (if_a.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_len20 got %b exp 1", if_a.busy); end
    tick();
    n_checks++;
    if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_len21 got %b exp 0", if_a.busy); end
  endtask

  task automatic test_top_and_strike3();
    logic eb_a, ez_a, eb_b, ez_b;
    drive(1'b1, 7'd0, 7'd59, 7'd59, 5'd15);
    repeat (25) tick();
    n_checks++;
    if (busy_all !== 3'b000) begin n_fail++; $display("FAIL top_pre_busy got %b exp 000", busy_all); end
    drive(1'b1, 7'd0, 7'd0, 7'd0, 5'd15);
    for (int i = 0; i < 43; i++) begin
      tick();
      eb_a = (i < 40);
      ez_a = (i < 40) && (((i / 5) % 2) == 0);
      eb_b = (i < 42);
      ez_b = (i < 42) && ((i % 16) < 5);
      n_checks++;
      if (if_a.busy !== eb_a) begin n_fail++; $display("FAIL top_busy cyc %0d got %b exp %b", i, if_a.busy, eb_a); end
      n_checks++;
      if (if_a.buzz !== ez_a) begin n_fail++; $display("FAIL top_buzz cyc %0d got %b exp %b", i, if_a.buzz, ez_a); end
      n_checks++;
      if (if_b.busy !== eb_b) begin n_fail++; $display("FAIL strike3_busy cyc %0d got %b exp %b", i, if_b.busy, eb_b); end
      n_checks++;
      if (if_b.buzz !== ez_b) begin n_fail++; $display("FAIL strike3_buzz cyc %0d got %b exp %b", i, if_b.buzz, ez_b); end
    end
  endtask

  task automatic test_strike12();
    int len;
    drive(1'b1, 7'd0, 7'd1, 7'd0, 5'd0);
    repeat (5) tick();
    drive(1'b1, 7'd0, 7'd0, 7'd0, 5'd0);
    tick();
    len = 0;
    while ((if_b.busy === 1'b1) && (len < 300)) begin
      len++;
      tick();
    end
    n_checks++;
    if (len != 186) begin n_fail++; $display("FAIL strike12_len got %0d exp 186", len); end
  endtask

  task automatic test_mute();
    drive(1'b1, 7'd1, 7'd49, 7'd59, 5'd0);
    repeat (3) tick();
    drive(1'b1, 7'd1, 7'd50, 7'd59, 5'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (busy_all !== 3'b000) begin n_fail++; $display("FAIL mute_set_time cyc %0d got %b exp 000", i, busy_all); end
    end
    drive(1'b1, 7'd0, 7'd50, 7'd59, 5'd0);
    repeat (3) tick();
    n_checks++;
    if (busy_all !== 3'b000) begin n_fail++; $display("FAIL mute_unset got %b exp 000", busy_all); end
    drive(1'b1, 7'd0, 7'd59, 7'd59, 5'd5);
    repeat (3) tick();
    drive(1'b1, 7'd0, 7'd0, 7'd0, 5'd5);
    repeat (10) tick();
    n_checks++;
    if (if_a.busy !== 1'b1) begin n_fail++; $display("FAIL mute_top_running got %b exp 1", if_a.busy); end
    drive(1'b0, 7'd0, 7'd0, 7'd0, 5'd5);
    tick();
    n_checks++;
    if (busy_all !== 3'b000) begin n_fail++; $display("FAIL mute_en_busy got %b exp 000", busy_all); end
    n_checks++;
    if (buzz_all !== 3'b000) begin n_fail++; $display("FAIL mute_en_buzz got %b exp 000", buzz_all); end
    repeat (3) tick();
    drive(1'b1, 7'd0, 7'd0, 7'd0, 5'd5);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (busy_all !== 3'b000) begin n_fail++; $display("FAIL mute_resume cyc %0d got %b exp 000", i, busy_all); end
    end
  endtask

  task automatic test_reset_mid_strike();
    drive(1'b1, 7'd0, 7'd59, 7'd59, 5'd3);
    repeat (3) tick();
    drive(1'b1, 7'd0, 7'd0, 7'd0, 5'd3);
    repeat (15) tick();
    n_checks++;
    if (if_b.busy !== 1'b1) begin n_fail++; $display("FAIL rst_strike_running got %b exp 1", if_b.busy); end
    rst = 1'b1;
    drive(1'b1, 7'd0, 7'd30, 7'd0, 5'd3);
    tick();
    n_checks++;
    if (busy_all !== 3'b000) begin n_fail++; $display("FAIL rst_mid_busy got %b exp 000", busy_all); end
    n_checks++;
    if (buzz_all !== 3'b000) begin n_fail++; $display("FAIL rst_mid_buzz got %b exp 000", buzz_all); end
    n_checks++;
    if (if_b.dbg_state !== 3'd0) begin n_fail++; $display("FAIL rst_mid_state got %0d exp 0", if_b.dbg_state); end
    drive(1'b1, 7'd0, 7'd0, 7'd0, 5'd3);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (busy_all !== 3'b000) begin n_fail++; $display("FAIL rst_release_top cyc %0d got %b exp 000", i, busy_all); end
    end
  endtask

  // Test sequence and final report
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1'b1, 7'd0, 7'd0, 7'd0, 5'd0);
    test_reset();
    test_pip();
    test_pip_window();
    test_back_to_back();
    test_top_and_strike3();
    test_strike12();
    test_mute();
    test_reset_mid_strike();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/chime_ctrl.md
# chime_ctrl

Parametrised hourly chime controller for the digital clock. It watches the running time-of-day and drives the piezo `buzz` pin. Before the hour it sounds a configurable number of short high-tone pips; at the top of the hour it sounds one long low tone, or optionally strikes the hour count. It sits beside the time counters and takes over from the fixed five-pip chime, adding mute, a busy flag, deterministic tone phase and strike mode.

## Interface
- `TONE_HI_DIV`, 50000: high (pip) tone half-period in clk cycles.
- `TONE_LO_DIV`, 62500: low (hour) tone half-period in clk cycles.
- `PRE_BEEPS`, 5: number of pips before the hour, legal range 0..29.
- `BEEP_CYC`, 25_000_000: pip length in cycles; must be less than 2 s of clk.
- `TOP_CYC`, 50_000_000: length of the single top-of-hour tone.
- `STRIKE_EN`, 0: 1 selects hour strikes instead of the single top tone.
- `STRIKE_ON_CYC`, 25_000_000: length of each strike tone.
- `STRIKE_GAP_CYC`, 25_000_000: silence between strikes.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  chime enable; 0 mutes.
- `set_time`  in  7  nonzero while the user is setting the time; nonzero mutes.
- `S_in`  in  7  seconds, 0..59.
- `M_in`  in  7  minutes, 0..59.
- `H_in`  in  5  hours, 0..23.
- `buzz`  out  1  square-wave drive to the buzzer.
- `busy`  out  1  high while a pip, tone, strike or gap is in progress.

## Operation
- **Mute:** `mute = !en || (set_time != 0)`.
- **Second-edge detect:** `s_q` is a registered copy of `S_in`. `new_sec = (S_in != s_q) && !mute`. During `rst`, `s_q` loads `S_in`, so no trigger fires on release of reset.
- **Triggers:** evaluated only on `new_sec`.
  - PIP: `M_in == 59`, `S_in` even, and `S_in >= 60 - 2*PRE_BEEPS`.
  - TOP: `M_in == 0` and `S_in == 0`.
  - A trigger that arrives while busy pre-empts the current activity and restarts.
- **FSM states:** IDLE, PIP, TOP, STRK_ON, STRK_GAP.
  - IDLE → PIP on a PIP trigger.
  - IDLE → TOP on a TOP trigger when `STRIKE_EN == 0`.
  - IDLE → STRK_ON on a TOP trigger when `STRIKE_EN == 1`. On entry, `n` loads `H_in mod 12`, with 0 mapped to 12.
  - PIP → IDLE after `BEEP_CYC` cycles. TOP → IDLE after `TOP_CYC` cycles.
  - STRK_ON runs for `STRIKE_ON_CYC` cycles, then decrements `n`. If `n` reaches 0 it goes to IDLE; otherwise it goes to STRK_GAP.
  - STRK_GAP → STRK_ON after `STRIKE_GAP_CYC` cycles.
- **Mute or reset in any state:** next state is IDLE and the duration counter clears.
- **Tone generator:** one shared divider counter and phase register.
  - Counter clears and phase sets to 1 on entry to PIP, TOP or STRK_ON.
  - Phase toggles each time the counter reaches DIV−1; the counter then wraps to 0. DIV is `TONE_HI_DIV` in PIP and `TONE_LO_DIV` otherwise.
  - Resulting period is 2·DIV cycles with 50% duty, first half high.
- **Outputs:** `buzz` = phase in PIP, TOP and STRK_ON, else 0. `busy` = (state != IDLE). Both are registered.
- **Counter widths:** duration counter is `$clog2` of the largest duration parameter; divider counter is `$clog2` of the larger DIV.
- **Timing inputs:** `S_in`, `M_in` and `H_in` must be stable in the `clk` domain.

## Timing
- **Reset values:** `buzz = 0`, `busy = 0`, state IDLE, all counters 0, phase 0.
- **Latency:** `new_sec` is seen in cycle t; state, `busy = 1` and `buzz = 1` appear in cycle t+1.
- **Durations:** a tone of length L keeps `busy` high for exactly L cycles (t+1 .. t+L). `busy = 0` at t+L+1.
- **Strike sequence:** total busy length is N·`STRIKE_ON_CYC` + (N−1)·`STRIKE_GAP_CYC`, with no gap after the last strike.
- **Mute asserted in cycle m:** `buzz = 0` and `busy = 0` from m+1.
- **Pre-emption:** a trigger in the final busy cycle restarts at t+1 with no idle cycle in between.
- **Out-of-range inputs:** `S_in` or `M_in` > 59 never trigger. `H_in` > 23 is reduced mod 12 as above.

## Test plan
Simulation parameters: `TONE_HI_DIV=4`, `TONE_LO_DIV=5`, `BEEP_CYC=20`, `TOP_CYC=40`, `STRIKE_ON_CYC=10`, `STRIKE_GAP_CYC=6`, `PRE_BEEPS=5`.

- **Pip:** step 59:49 → 59:50 → `busy` high for 20 cycles starting the next cycle. `buzz` reads 1111 0000 1111 0000 1111, then 0.
- **Pip window:** 59:48 and 59:51 → no `busy`. 59:50, 52, 54, 56, 58 → five pips. With `PRE_BEEPS=2`, only 59:56 and 59:58 pip.
- **Top tone:** 59:59 → 00:00 with `STRIKE_EN=0` → 40 cycles of `busy`, `buzz` period 10 (5 high, 5 low), starting high.
- **Strike:** `STRIKE_EN=1`, `H_in=15` → 3 strikes, `busy` length 3·10 + 2·6 = 42. `H_in=0` → 12 strikes, length 186.
- **Mute:** `set_time=1` during 59:50 → no `busy`. Raise `en=0` mid-TOP → `buzz=0` and `busy=0` next cycle; no resumption when `en` returns to 1.
- **Reset:** assert `rst` mid-strike → IDLE with all outputs 0. Release `rst` with `S_in=0`, `M_in=0` → no spurious TOP.
